cm_rr_merge: RTL and testbench
==============================

# cm_rr_merge

Clocked N-input merge for the data-driven token pipeline. It generalises the two-input CM merge to N channels, with configurable data width and output buffer depth, and a selectable arbitration mode (round-robin or fixed priority). Every token is tagged with the index of its source channel, and an output FIFO decouples the merge from downstream stalls. It sits upstream of a C pipeline stage, whose Send/Ack pair connects directly to Send_out/Ack_in.

## Interface
- N, 4: number of input channels (≥2).
- W, 8: data width per channel.
- DEPTH, 4: output FIFO depth (power of two, ≥2).
- MODE, 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- SW = max(1, clog2(N)) is a derived width; CW = clog2(DEPTH+1) is a derived width.

- CLK  in  1  clock; all state changes on the rising edge.
- MR  in  1  master reset; one clock, reset is synchronous and active-high.
- Send_in  in  N  per-channel request, active-low (0 = token offered).
- Data_in  in  N*W  packed channel data; channel i occupies [i*W +: W].
- Ack_out  out  N  per-channel acknowledge, active-low; combinational.
- Send_out  out  1  output token valid, active-low; registered.
- Data_out  out  W  head-of-FIFO data.
- Sel_out  out  SW  head-of-FIFO source channel index.
- Ack_in  in  1  downstream acknowledge, active-low.
- CP  out  N  one-cycle high pulse, registered; CP[i]=1 in the cycle after channel i's token is accepted.
- Level  out  CW  FIFO occupancy.
- Full  out  1  Level == DEPTH.

## Operation
- **Input transfer:** channel i transfers at a rising edge when Send_in[i]==0 and Ack_out[i]==0. At most one channel transfers per edge.
- **Grant:** Ack_out[i]=0 only when all of the following hold:
  - MR==0;
  - Level<DEPTH;
  - channel i is the arbiter winner among the channels with Send_in==0.
  - All other Ack_out bits are 1.
- **No pass-through:** when the FIFO is full, no grant is issued, even if a pop occurs in the same cycle. Ack_out never depends on Ack_in.
- **Round-robin (MODE=0):**
  - A pointer holds the last granted index.
  - The search starts at last+1 and wraps modulo N.
  - The pointer updates only on a transfer.
- **Fixed priority (MODE=1):** the lowest requesting index wins. The pointer is unused.
- **Push:** an accepted token writes {i, Data_in[i]} at the write pointer. The write pointer increments modulo DEPTH.
- **Output transfer:**
  - Send_out=0 whenever Level>0; Send_out=1 when empty.
  - A pop occurs at an edge where Send_out==0 and Ack_in==0. The read pointer increments modulo DEPTH.
  - Ack_in is ignored while the FIFO is empty.
- **Level update:** push only: +1. Pop only: −1. Push and pop together: unchanged.
- **Ordering:** tokens leave in acceptance order. No token is lost or duplicated.
- **Data_out/Sel_out:** reflect the head entry whenever Send_out==0. When empty they hold their last value (0 after reset).

## Timing
- **Reset (MR==1 at an edge):**
  - Level=0 and both FIFO pointers=0.
  - RR pointer=N-1, so channel 0 has first priority.
  - Send_out=1, Data_out=0, Sel_out=0, CP=0, Full=0.
  - Ack_out is all ones combinationally for as long as MR==1.
- **Reset mid-operation:** all buffered tokens are discarded. Send_out=1 after the reset edge. Requests present during MR are not acknowledged.
- **Latency:** a token accepted at edge k is visible on Send_out/Data_out/Sel_out after edge k if the FIFO was empty, and is poppable at edge k+1.
- **Throughput:** one token per cycle sustained when Ack_in is held at 0.
- **CP[i]:** high for exactly the one cycle following the accepting edge.
- **Full/Level:** registered; both change after the edge that causes the change.
- **Upstream obligation:** Data_in[i] must be stable while Send_in[i]==0. Withdrawing a request before it is acknowledged is permitted; the block samples only at the edge.

## Test plan
- **Reset:** MR=1 for 3 cycles with Send_in=4'b0000 and Ack_in=0 → Ack_out=4'b1111, Send_out=1, CP=0 and Level=0 throughout. First edge after MR falls → channel 0 is acknowledged.
- **Single stream:** N=4, W=8, Send_in[2]=0 held with Data_in[2]=0x10,0x11,0x12 on consecutive cycles, Ack_in=0 → Send_out low from the cycle after the first accept, Data_out=0x10,0x11,0x12, Sel_out=2, CP[2] pulses once per token, Level stays ≤1.
- **All request, MODE=0:** Send_in=0000, Ack_in=0 → grant order 0,1,2,3,0,1 and Sel_out in the same order. Same stimulus with MODE=1 → only channel 0 is acknowledged; channels 1–3 get Ack_out=1.
- **Backpressure:** DEPTH=4, Ack_in=1, all channels requesting → exactly 4 accepts, then Full=1 and Ack_out=1111. Set Ack_in=0 → 4 pops in acceptance order, and a new grant is issued once Level reaches 3.
- **Simultaneous push/pop:** with Level=1, one push and one pop at the same edge → Level stays 1 and FIFO order is preserved. With Level=DEPTH and a pop → no grant in that cycle.
- **Mid-operation reset:** Level=3, MR=1 for one cycle → Send_out=1 and Level=0 after the edge, none of the 3 tokens appears on the output, and RR restarts at channel 0.

Source files
------------

// File: rtl/cm_rr_merge.sv
`default_nettype none
// ============================================================================
// cm_rr_merge : N-input token merge with round-robin / fixed-priority
//               arbitration, source tagging and an output FIFO.
// Revision    : 1.0
// ============================================================================
module cm_rr_merge #(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    parameter  int MODE  = 0,
    localparam int SW    = (N > 1) ? $clog2(N) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            MR,
    input  logic [N-1:0]    Send_in,
    input  logic [N*W-1:0]  Data_in,
    output logic [N-1:0]    Ack_out,
    output logic            Send_out,
    output logic [W-1:0]    Data_out,
    output logic [SW-1:0]   Sel_out,
    input  logic            Ack_in,
    output logic [N-1:0]    CP,
    output logic [CW-1:0]   Level,
    output logic            Full
);

    localparam int           c_pw  = $clog2(DEPTH);
    localparam logic [N-1:0] c_one = N'(1);

    logic [W-1:0]    r_mem_data [DEPTH];
    logic [SW-1:0]   r_mem_sel  [DEPTH];
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [CW-1:0]   r_level;
    logic            r_full;
    logic            r_send_out;
    logic [W-1:0]    r_data_out;
    logic [SW-1:0]   r_sel_out;
    logic [N-1:0]    r_cp;
    logic [SW-1:0]   r_rr_last;

    logic [N-1:0]    w_req;
    logic            w_lo_valid;
    logic [SW-1:0]   w_lo_idx;
    logic            w_hi_valid;
    logic [SW-1:0]   w_hi_idx;
    logic            w_win_valid;
    logic [SW-1:0]   w_win_idx;
    logic            w_can_accept;
    logic            w_push;
    logic            w_pop;
    logic [N-1:0]    w_grant;
    logic [W-1:0]    w_in_data;
    logic [CW-1:0]   w_level_nxt;
    logic [c_pw-1:0] w_rd_nxt;
    logic [W-1:0]    w_head_data;
    logic [SW-1:0]   w_head_sel;

    assign w_req = ~Send_in;

    // Two passes: lowest requester strictly above the last grant, else lowest overall.
    always_comb begin
        w_lo_valid = 1'b0;
        w_lo_idx   = '0;
        w_hi_valid = 1'b0;
        w_hi_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_lo_valid = 1'b1;
                w_lo_idx   = SW'(i);
            end
            if (w_req[i] && (i > int'(r_rr_last))) begin
                w_hi_valid = 1'b1;
                w_hi_idx   = SW'(i);
            end
        end
        if (MODE == 1) begin
            w_win_valid = w_lo_valid;
            w_win_idx   = w_lo_idx;
        end else begin
            w_win_valid = w_lo_valid;
            w_win_idx   = w_hi_valid ? w_hi_idx : w_lo_idx;
        end
    end

    // Grant uses the registered Full only, so a same-cycle pop never frees a slot.
    assign w_can_accept = ~MR & ~r_full;
    assign w_push       = w_win_valid & w_can_accept;
    assign w_grant      = w_push ? (c_one << w_win_idx) : '0;
    assign w_pop        = ~r_send_out & ~Ack_in;
    assign w_in_data    = Data_in[w_win_idx*W +: W];

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + CW'(1);
            2'b01:   w_level_nxt = r_level - CW'(1);
            default: w_level_nxt = r_level;
        endcase
        w_rd_nxt    = w_pop ? (r_rd_ptr + c_pw'(1)) : r_rd_ptr;
        w_head_data = r_data_out;
        w_head_sel  = r_sel_out;
        // The next head is the incoming token when it lands in an empty slot chain.
        if (w_level_nxt != '0) begin
            if ((r_level == '0) || (w_pop && (r_level == CW'(1)))) begin
                w_head_data = w_in_data;
                w_head_sel  = w_win_idx;
            end else begin
                w_head_data = r_mem_data[w_rd_nxt];
                w_head_sel  = r_mem_sel[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_in_data;
            r_mem_sel[r_wr_ptr]  <= w_win_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_send_out <= 1'b1;
            r_data_out <= '0;
            r_sel_out  <= '0;
            r_cp       <= '0;
            r_rr_last  <= SW'(N - 1);
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + c_pw'(1);
                r_rr_last <= w_win_idx;
            end
            r_rd_ptr   <= w_rd_nxt;
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == CW'(DEPTH));
            r_send_out <= (w_level_nxt == '0);
            r_data_out <= w_head_data;
            r_sel_out  <= w_head_sel;
            r_cp       <= w_grant;
        end
    end

    assign Ack_out  = ~w_grant;
    assign Send_out = r_send_out;
    assign Data_out = r_data_out;
    assign Sel_out  = r_sel_out;
    assign CP       = r_cp;
    assign Level    = r_level;
    assign Full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_cm_rr_merge.sv
`default_nettype none
// ============================================================================
// tb_cm_rr_merge : randomized bench comparing a round-robin and a fixed-priority
//                  instance against a queue-based reference model.
// Revision       : 1.0
// ============================================================================
module tb_cm_rr_merge;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 2;
    localparam int CW    = 3;

    typedef logic [SW+W-1:0] tok_t;

    logic           CLK;
    logic           MR;
    logic [N-1:0]   Send_in;
    logic [N*W-1:0] Data_in;
    logic           Ack_in;

    logic [N-1:0]   ack0, ack1;
    logic           send0, send1;
    logic [W-1:0]   data0, data1;
    logic [SW-1:0]  sel0, sel1;
    logic [N-1:0]   cp0, cp1;
    logic [CW-1:0]  lvl0, lvl1;
    logic           full0, full1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference state per instance (index 0 = round-robin, 1 = fixed priority)
    tok_t          q0[$];
    tok_t          q1[$];
    int            rr[2];
    logic [N-1:0]  cp_e[2];
    logic [W-1:0]  hd_d[2];
    logic [SW-1:0] hd_s[2];

    cm_rr_merge #(.N(N), .W(W), .DEPTH(DEPTH), .MODE(0)) dut0 (
        .CLK(CLK), .MR(MR), .Send_in(Send_in), .Data_in(Data_in),
        .Ack_out(ack0), .Send_out(send0), .Data_out(data0), .Sel_out(sel0),
        .Ack_in(Ack_in), .CP(cp0), .Level(lvl0), .Full(full0)
    );

    cm_rr_merge #(.N(N), .W(W), .DEPTH(DEPTH), .MODE(1)) dut1 (
        .CLK(CLK), .MR(MR), .Send_in(Send_in), .Data_in(Data_in),
        .Ack_out(ack1), .Send_out(send1), .Data_out(data1), .Sel_out(sel1),
        .Ack_in(Ack_in), .CP(cp1), .Level(lvl1), .Full(full1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic tok_t qfront(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int m, input tok_t t);
        if (m == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic qpop(input int m);
        if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qclear(input int m);
        if (m == 0) q0.delete(); else q1.delete();
    endtask

    // Arbiter winner from the rules: RR searches last+1.. modulo N, FP picks lowest.
    function automatic int winner(input int m);
        if (m == 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (rr[0] + k) % N;
                if (Send_in[j] == 1'b0) return j;
            end
        end else begin
            for (int j = 0; j < N; j++)
                if (Send_in[j] == 1'b0) return j;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            int           sz, w;
            logic [N-1:0] exp_ack;
            string        p;
            p  = (m == 0) ? "rr" : "fp";
            sz = qsize(m);
            w  = winner(m);
            exp_ack = '1;
            if (!MR && sz < DEPTH && w >= 0) exp_ack[w] = 1'b0;
            chk({p, "_ack"},   32'(m == 0 ? ack0  : ack1),  32'(exp_ack));
            chk({p, "_send"},  32'(m == 0 ? send0 : send1), 32'(sz == 0));
            chk({p, "_level"}, 32'(m == 0 ? lvl0  : lvl1),  32'(sz));
            chk({p, "_full"},  32'(m == 0 ? full0 : full1), 32'(sz == DEPTH));
            chk({p, "_cp"},    32'(m == 0 ? cp0   : cp1),   32'(cp_e[m]));
            chk({p, "_data"},  32'(m == 0 ? data0 : data1), 32'(hd_d[m]));
            chk({p, "_sel"},   32'(m == 0 ? sel0  : sel1),  32'(hd_s[m]));
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int   sz, w;
            logic push, pop;
            sz = qsize(m);
            w  = winner(m);
            if (MR) begin
                qclear(m);
                rr[m]   = N - 1;
                cp_e[m] = '0;
                hd_d[m] = '0;
                hd_s[m] = '0;
            end else begin
                push = (w >= 0) && (sz < DEPTH);
                pop  = (sz > 0) && (Ack_in == 1'b0);
                if (pop) qpop(m);
                cp_e[m] = '0;
                if (push) begin
                    qpush(m, {SW'(w), Data_in[w*W +: W]});
                    rr[m]      = w;
                    cp_e[m][w] = 1'b1;
                end
                if (qsize(m) > 0) begin
                    hd_s[m] = qfront(m)[SW+W-1:W];
                    hd_d[m] = qfront(m)[W-1:0];
                end
            end
        end
    endtask

    task automatic cycle(input logic mr_v, input logic [N-1:0] send_v, input logic ack_v);
        MR      = mr_v;
        Send_in = send_v;
        Ack_in  = ack_v;
        Data_in = (N*W)'($urandom);
        @(negedge CLK);
        check_outputs();
        @(posedge CLK);
        model_update();
        cyc++;
        #1;
    endtask

    initial begin
        MR      = 1'b1;
        Send_in = '0;
        Ack_in  = 1'b0;
        Data_in = '0;
        @(posedge CLK);
        model_update();
        #1;

        // Reset held with everyone requesting, then release
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 1'b0);

        // Single stream on channel 2
        cycle(1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b1011, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 1'b0);

        // Backpressure to full, then drain with requests still pending
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b1111, 1'b0);

        // Mid-operation reset with three tokens buffered
        cycle(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1101, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0000, 1'b0);

        // Random traffic with varying downstream stalls
        for (int i = 0; i < 300; i++)
            cycle(1'b0, N'($urandom), ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 39) == 0), N'($urandom), ($urandom_range(0, 1) == 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
